// File: rtl/bit_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_pkg
//  Description : Shared types, constants and helpers for the bit-stream
//                serializer (state encoding, default word width, output-bit
//                index selection).
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_stream_pkg;

    // Serializer control states: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned C_DEFAULT_WIDTH = 8;

    // Index of the shift-register bit that is presented on the serial output.
    function automatic int unsigned out_bit_index(input int unsigned width,
                                                  input bit          msb_first);
        return msb_first ? (width - 1) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_stream_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer_if
//  Description : Load handshake and serial output bundle of the serializer.
//                master = upstream/observer side, slave = serializer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  bit_out,
        input  bit_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output bit_out,
        output bit_valid,
        output word_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_stream_holdbuf.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_holdbuf
//  Description : One-entry valid/ready holding register. Accepts a word only
//                when empty; the consumer drains it with a one-cycle take.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_holdbuf #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             in_valid,
    input  wire logic [WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  wire logic             take,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    // Readiness depends only on the stored flag, never on in_valid.
    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state: take and accept are mutually exclusive (full vs. empty).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (take) begin
            valid_d = 1'b0;
        end
        if (in_valid && !valid_q) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bit_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer
//  Description : Parallel-in / serial-out stage. Buffers one word, shifts it
//                out one bit per clock with a valid qualifier and hands off
//                to the next buffered word without an idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_serializer
    import bit_stream_pkg::*;
#(
    parameter int WIDTH      = C_DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    bit_stream_serializer_if.slave bus
);

    localparam int          C_CNT_W   = $clog2(WIDTH);
    localparam int unsigned C_OUT_IDX = out_bit_index(WIDTH, MSB_FIRST);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    state_t               state_d, state_q;
    logic [WIDTH-1:0]     shift_d, shift_q;
    logic [C_CNT_W-1:0]   cnt_d,   cnt_q;

    logic                 w_hold_valid;
    logic [WIDTH-1:0]     w_hold_data;
    logic                 w_take;
    logic                 w_last;
    logic [WIDTH-1:0]     w_shift_next;

    logic                 w_bit_out;
    logic                 w_bit_valid;
    logic                 w_word_done;

    bit_stream_holdbuf #(
        .WIDTH (WIDTH)
    ) u_holdbuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.load_valid),
        .in_data   (bus.load_data),
        .in_ready  (bus.load_ready),
        .take      (w_take),
        .out_valid (w_hold_valid),
        .out_data  (w_hold_data)
    );

    // Move the shift register one position toward the output end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shift_next = {1'b0, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (state_q == SHIFT) && (cnt_q == C_LAST);
    // The held word moves into the shifter when idle, or on the last bit.
    assign w_take = w_hold_valid && ((state_q == IDLE) || w_last);

    // Next-state and output decode for the two-state shifter.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        w_bit_valid = 1'b0;
        w_bit_out   = IDLE_LEVEL;
        w_word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_hold_valid) begin
                    shift_d = w_hold_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                w_bit_valid = 1'b1;
                w_bit_out   = shift_q[C_OUT_IDX];
                w_word_done = w_last;
                if (!w_last) begin
                    shift_d = w_shift_next;
                    cnt_d   = cnt_q + C_CNT_W'(1);
                end else if (w_hold_valid) begin
                    shift_d = w_hold_data;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shifter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bit_out   = w_bit_out;
    assign bus.bit_valid = w_bit_valid;
    assign bus.word_done = w_word_done;
    assign bus.busy      = (state_q == SHIFT) || w_hold_valid;

endmodule
`default_nettype wire

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the serial pattern detector and drives its one-bit `din` input.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register.
- Shifts each word out one bit per clock with a bit-valid qualifier.
- Back-to-back words stream with no idle gap between them.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_LEVEL, 0: value driven on bit_out whenever bit_valid is 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream word available.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  holding register empty; a word is accepted when load_valid && load_ready at a clk edge.
- bit_out  output  1  serial data, registered; feeds the detector's din.
- bit_valid  output  1  bit_out carries a payload bit this cycle.
- word_done  output  1  high during the cycle the last bit of a word is on bit_out.
- busy  output  1  shifter active or holding register full.

Behaviour:
- Reset (async assert, sync deassert expected from the system):
  - state=IDLE, shift_reg=0, bit_cnt=0, hold_valid=0, hold_data=0.
  - Outputs: load_ready=1, bit_out=IDLE_LEVEL, bit_valid=0, word_done=0, busy=0.
- Holding register (one entry):
  - load_ready = !hold_valid, a function of registered state only.
  - On accept: hold_data<=load_data, hold_valid<=1.
  - load_data is ignored when no accept occurs.
- State machine, 2 states:
  - IDLE: bit_valid=0, bit_out=IDLE_LEVEL. If hold_valid at an edge: shift_reg<=hold_data, bit_cnt<=0, hold_valid<=0, go to SHIFT.
  - SHIFT: bit_valid=1, bit_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0].
    - Each edge: if bit_cnt<WIDTH-1, shift toward the output end and bit_cnt++.
    - If bit_cnt==WIDTH-1 (last bit) and hold_valid: reload shift_reg from hold, bit_cnt<=0, hold_valid<=0, stay in SHIFT. This is the gapless handoff.
    - If bit_cnt==WIDTH-1 and !hold_valid: go to IDLE.
- word_done = (state==SHIFT) && (bit_cnt==WIDTH-1).
- busy = (state==SHIFT) || hold_valid.
- Latency: word accepted at edge N → hold at N → shifter load at N+1 → first bit on bit_out in cycle N+1..N+2 → last bit in cycle N+WIDTH..N+WIDTH+1.
- Simultaneous accept and hold→shifter move at the same edge cannot occur, because accept requires hold empty. load_ready rises the cycle after hold drains.
- load_valid held high while load_ready=0: no accept, hold contents unchanged.
- bit_cnt width: $clog2(WIDTH). No wrap-around beyond WIDTH-1.
- Reset mid-word: the current word and the held word are discarded immediately; outputs go to reset values within the same cycle.

Decomposition:
- Shared package bit_stream_pkg:
  - state enum {IDLE, SHIFT}.
  - Default WIDTH constant.
  - Function selecting the output bit index from MSB_FIRST.
- One sub-module: bit_stream_holdbuf, the one-entry valid/ready holding register (clk, rst, in_valid, in_data, in_ready, take, out_valid, out_data).

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge → load_ready=1, bit_valid=0, bit_out=0, busy=0, word_done=0 immediately.
- Single word: WIDTH=8, MSB_FIRST=1, accept 8'h96 at edge N → bit_out=1,0,0,1,0,1,1,0 over 8 consecutive cycles starting after edge N+1; bit_valid high exactly 8 cycles; word_done only on the 8th; then IDLE.
- Back-to-back: offer 8'hF0 then 8'h0F with load_valid held high → 16 contiguous bit_valid cycles, sequence 11110000_00001111; load_ready=0 while hold is full; exactly 2 accepts.
- LSB-first: MSB_FIRST=0, accept 8'h01 → bit_out=1,0,0,0,0,0,0,0.
- Reset mid-word: assert rst after 3 bits of 8'hAA with hold full → bit_valid=0, hold empty, load_ready=1; after release no further bits until a new accept.
- Downstream link: stream 8'h09 (MSB first, bits 0000_1001) into the detector → detector output asserts one cycle after the final 1 is presented.
